wash_program_sequencer: RTL and testbench

Sequences the wash actuators (inlet valve, drain valve, drum motor) through the stages selected on the front panel. Each selected stage runs fill → agitate → drain, with per-phase timers, water-level sensor handshakes and fill/drain timeouts. The block sits between the panel/mode logic, which supplies start, pause, stage mask and mode, and the actuator drivers. It also feeds the stage and time LEDs.

---
 rtl/wash_program_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_wash_program_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_program_sequencer.sv
// wash_program_sequencer
//   Steps the wash actuators through the stages picked on the front panel.
//   Each selected stage runs fill -> agitate -> drain. The spin stage skips
//   fill and agitate and runs drain -> high-speed spin. Sensor handshakes
//   end the fill and drain phases. A timeout on either phase latches a fault.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           one-cycle request; launches from IDLE, clears FAULT
//   pause           level; freezes an active program, actuators forced off
//   stage_sel[3:0]  soak/wash/rinse/spin mask, sampled at start
//   mode[2:0]       one-hot light/normal/heavy, sampled at start
//   level_full/level_empty  water-level sensors
//   inlet_valve, drain_valve, motor_on, motor_fast  actuator commands
//   cur_stage[3:0]  one-hot active stage
//   time_left[4:0]  remaining time units in RUN/SPIN
//   busy, done, warning  status
module wash_program_sequencer #(
  parameter int TICK_DIV      = 1,
  parameter int FILL_TIMEOUT  = 8,
  parameter int DRAIN_TIMEOUT = 8,
  parameter int SPIN_T        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] stage_sel,
  input  logic [2:0] mode,
  input  logic       level_full,
  input  logic       level_empty,
  output logic       inlet_valve,
  output logic       drain_valve,
  output logic       motor_on,
  output logic       motor_fast,
  output logic [3:0] cur_stage,
  output logic [4:0] time_left,
  output logic       busy,
  output logic       done,
  output logic       warning
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TO_MAX = (FILL_TIMEOUT > DRAIN_TIMEOUT) ? FILL_TIMEOUT : DRAIN_TIMEOUT;
  localparam int TO_W   = $clog2(TO_MAX + 2);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [TO_W-1:0]  FILL_LD  = TO_W'(FILL_TIMEOUT);
  localparam logic [TO_W-1:0]  DRAIN_LD = TO_W'(DRAIN_TIMEOUT);
  localparam logic [4:0]       SPIN_LD  = 5'(SPIN_T);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_RUN, S_DRAIN, S_SPIN, S_NEXT, S_FINISH, S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        pend_q, pend_d;   // stages still to run
  logic [3:0]        cur_q, cur_d;     // one-hot stage in progress
  logic [3:0]        dur_q, dur_d;     // agitate duration latched at start
  logic [4:0]        tl_q, tl_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              warn_q, warn_d;

  logic timed, active, frozen, tick;

  function automatic logic [3:0] lowest(input logic [3:0] m);
    return m & (~m + 4'd1);
  endfunction

  // Spin has no fill/agitate phase, so its entry point is DRAIN.
  function automatic state_t entry_of(input logic [3:0] m);
    return (m[2:0] != 3'b000) ? S_FILL : S_DRAIN;
  endfunction

  function automatic logic [3:0] dur_of(input logic [2:0] md);
    logic [3:0] r;
    case (md)
      3'b001:  r = 4'd3;
      3'b100:  r = 4'd9;
      default: r = 4'd6;
    endcase
    return r;
  endfunction

  assign timed  = (state_q == S_FILL) || (state_q == S_RUN) ||
                  (state_q == S_DRAIN) || (state_q == S_SPIN);
  assign active = timed || (state_q == S_NEXT);
  assign frozen = active && pause;
  assign tick   = timed && (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    dur_d   = dur_q;
    tl_d    = tl_q;
    div_d   = div_q;
    to_d    = to_q;
    warn_d  = warn_q;

    if (!frozen) begin
      if (timed) div_d = tick ? '0 : div_q + DIV_W'(1);

      case (state_q)
        S_IDLE: begin
          if (start && (stage_sel != 4'b0000)) begin
            pend_d  = stage_sel;
            dur_d   = dur_of(mode);
            cur_d   = lowest(stage_sel);
            state_d = entry_of(stage_sel);
          end
        end
        S_FILL: begin
          // level_full beats a same-cycle timeout expiry
          if (level_full) begin
            state_d = S_RUN;
            tl_d    = {1'b0, dur_q};
          end else if (tick) begin
            if (to_q == TO_W'(1)) begin
              state_d = S_FAULT;
              warn_d  = 1'b1;
            end else begin
              to_d = to_q - TO_W'(1);
            end
          end
        end
        S_RUN: begin
          if (tick) begin
            tl_d = tl_q - 5'd1;
            if (tl_q == 5'd1) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (level_empty) begin
            if (cur_q[3]) begin
              state_d = S_SPIN;
              tl_d    = SPIN_LD;
            end else begin
              state_d = S_NEXT;
            end
          end else if (tick) begin
            if (to_q == TO_W'(1)) begin
              state_d = S_FAULT;
              warn_d  = 1'b1;
            end else begin
              to_d = to_q - TO_W'(1);
            end
          end
        end
        S_SPIN: begin
          if (tick) begin
            tl_d = tl_q - 5'd1;
            if (tl_q == 5'd1) state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          pend_d = pend_q & ~cur_q;
          if ((pend_q & ~cur_q) != 4'b0000) begin
            cur_d   = lowest(pend_q & ~cur_q);
            state_d = entry_of(pend_q & ~cur_q);
          end else begin
            cur_d   = 4'b0000;
            state_d = S_FINISH;
          end
        end
        S_FINISH: state_d = S_IDLE;
        S_FAULT: begin
          // start only acknowledges the fault; it never launches a program here
          if (start) begin
            state_d = S_IDLE;
            warn_d  = 1'b0;
            cur_d   = 4'b0000;
            pend_d  = 4'b0000;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Every phase entry restarts the divider and loads that phase's timeout.
      if (state_d != state_q) begin
        div_d = '0;
        if (state_d == S_FILL)  to_d = FILL_LD;
        if (state_d == S_DRAIN) to_d = DRAIN_LD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      cur_q   <= '0;
      dur_q   <= '0;
      tl_q    <= '0;
      div_q   <= '0;
      to_q    <= '0;
      warn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
      dur_q   <= dur_d;
      tl_q    <= tl_d;
      div_q   <= div_d;
      to_q    <= to_d;
      warn_q  <= warn_d;
    end
  end

  // Moore decode of the registered state; pause drops actuators the same cycle.
  assign inlet_valve = (state_q == S_FILL) && !pause;
  assign drain_valve = ((state_q == S_DRAIN) || (state_q == S_SPIN)) && !pause;
  assign motor_on    = (((state_q == S_RUN) && !cur_q[0]) || (state_q == S_SPIN)) && !pause;
  assign motor_fast  = (state_q == S_SPIN) && !pause;
  assign cur_stage   = cur_q;
  assign time_left   = ((state_q == S_RUN) || (state_q == S_SPIN)) ? tl_q : 5'd0;
  assign busy        = active;
  assign done        = (state_q == S_FINISH);
  assign warning     = warn_q;

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Bench for wash_program_sequencer: reset check, a cycle table for the
// directed wash-only / spin-only programs, an async-reset-mid-spin sequence,
// then random programs expanded into a per-cycle expected timeline.
module tb_wash_program_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0, pause = 1'b0;
  logic       level_full = 1'b0, level_empty = 1'b0;
  logic [3:0] stage_sel = 4'b0000;
  logic [2:0] mode = 3'b010;
  logic       inlet_valve, drain_valve, motor_on, motor_fast;
  logic [3:0] cur_stage;
  logic [4:0] time_left;
  logic       busy, done, warning;

  localparam int SPIN_T = 4;
  localparam int TMO    = 8;

  wash_program_sequencer #(
    .TICK_DIV(1), .FILL_TIMEOUT(TMO), .DRAIN_TIMEOUT(TMO), .SPIN_T(SPIN_T)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stage_sel(stage_sel),
    .mode(mode), .level_full(level_full), .level_empty(level_empty),
    .inlet_valve(inlet_valve), .drain_valve(drain_valve), .motor_on(motor_on),
    .motor_fast(motor_fast), .cur_stage(cur_stage), .time_left(time_left),
    .busy(busy), .done(done), .warning(warning)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [3:0] sel;
    logic [2:0] mode;
    logic       lf;
    logic       le;
    logic       pause;
    logic [15:0] exp;
  } vec_t;

  vec_t q[$];
  vec_t tbl[20];
  int   n_chk = 0;
  int   n_fail = 0;

  wire [15:0] obs = {inlet_valve, drain_valve, motor_on, motor_fast,
                     cur_stage, time_left, busy, done, warning};

  // expected output word: inlet, drain, motor, fast, cur_stage, time_left, busy, done, warning
  function automatic logic [15:0] pk(input logic i, input logic d, input logic m,
                                     input logic f, input logic [3:0] c,
                                     input logic [4:0] t, input logic b,
                                     input logic dn, input logic w);
    return {i, d, m, f, c, t, b, dn, w};
  endfunction

  function automatic vec_t mk(input logic st, input logic [3:0] sel, input logic [2:0] md,
                              input logic lf, input logic le, input logic pa,
                              input logic [15:0] e);
    vec_t v;
    v.start = st; v.sel = sel; v.mode = md; v.lf = lf; v.le = le; v.pause = pa; v.exp = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] e, input int idx);
    n_chk++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h (iv,dv,mo,mf,cur,tl,busy,done,warn)",
               nm, idx, obs, e);
    end
  endtask

  task automatic drive(input vec_t v);
    start = v.start; stage_sel = v.sel; mode = v.mode;
    level_full = v.lf; level_empty = v.le; pause = v.pause;
  endtask

  // inputs live from posedge+1; outputs sampled at the following negedge
  task automatic run_vec(input string nm, input vec_t v, input int idx);
    drive(v);
    @(negedge clk);
    check(nm, v.exp, idx);
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference timeline model ----------------
  // A cycle where pause has no effect (IDLE, FINISH, FAULT).
  task automatic push_plain(input logic st, input logic [3:0] sel, input logic [2:0] md,
                            input logic [15:0] e);
    vec_t v;
    v = mk(st, sel, md, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), e);
    q.push_back(v);
  endtask

  // A cycle of an active program. Optionally preceded by a burst of paused
  // copies: the program is frozen, so they show the same state with the
  // actuators off, and their sensor/start noise must be ignored.
  // sens: 0 free, 1 lf=0, 2 lf=1, 3 le=0, 4 le=1
  task automatic push_busy(input logic [15:0] e, input int sens);
    vec_t v;
    int n;
    if ($urandom_range(0, 9) == 0) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        v = mk(($urandom_range(0, 3) == 0), 4'($urandom), 3'($urandom),
               1'($urandom), 1'($urandom), 1'b1, e & 16'h0FFF);
        q.push_back(v);
      end
    end
    v = mk(($urandom_range(0, 5) == 0), 4'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom), 1'b0, e);
    case (sens)
      1: v.lf = 1'b0;
      2: v.lf = 1'b1;
      3: v.le = 1'b0;
      4: v.le = 1'b1;
      default: ;
    endcase
    q.push_back(v);
  endtask

  task automatic fault_tail(input logic [3:0] c);
    int n;
    n = $urandom_range(1, 3);
    repeat (n) push_plain(1'b0, 4'($urandom), 3'($urandom), pk(0, 0, 0, 0, c, 0, 0, 0, 1));
    // start with a non-empty mask only clears the fault
    push_plain(1'b1, 4'($urandom_range(1, 15)), 3'($urandom), pk(0, 0, 0, 0, c, 0, 0, 0, 1));
  endtask

  // flt: 0 none, 1 fill timeout on first wet stage, 2 drain timeout on first stage
  task automatic gen_prog(input logic [3:0] m, input logic [2:0] md, input int flt);
    int dd, f, d, n;
    logic [3:0] c;
    bit first;
    first = 1'b1;
    dd = (md == 3'b001) ? 3 : (md == 3'b100) ? 9 : 6;
    push_plain(1'b1, m, md, 16'h0000);
    for (int s = 0; s < 4; s++) begin
      if (m[s]) begin
        c = 4'(1 << s);
        if (s < 3) begin
          if (flt == 1 && first) begin
            repeat (TMO) push_busy(pk(1, 0, 0, 0, c, 0, 1, 0, 0), 1);
            fault_tail(c);
            return;
          end
          // delay 7 makes level_full coincide with the last timeout cycle
          f = ($urandom_range(0, 3) == 0) ? TMO - 1 : $urandom_range(0, 3);
          repeat (f) push_busy(pk(1, 0, 0, 0, c, 0, 1, 0, 0), 1);
          push_busy(pk(1, 0, 0, 0, c, 0, 1, 0, 0), 2);
          for (int t = dd; t >= 1; t--)
            push_busy(pk(0, 0, (s != 0), 0, c, 5'(t), 1, 0, 0), 0);
        end
        if (flt == 2 && first) begin
          repeat (TMO) push_busy(pk(0, 1, 0, 0, c, 0, 1, 0, 0), 3);
          fault_tail(c);
          return;
        end
        d = ($urandom_range(0, 3) == 0) ? TMO - 1 : $urandom_range(0, 3);
        repeat (d) push_busy(pk(0, 1, 0, 0, c, 0, 1, 0, 0), 3);
        push_busy(pk(0, 1, 0, 0, c, 0, 1, 0, 0), 4);
        if (s == 3)
          for (int t = SPIN_T; t >= 1; t--)
            push_busy(pk(0, 1, 1, 1, c, 5'(t), 1, 0, 0), 0);
        push_busy(pk(0, 0, 0, 0, c, 0, 1, 0, 0), 0);
        first = 1'b0;
      end
    end
    push_plain(1'b0, 4'h0, 3'b000, pk(0, 0, 0, 0, 4'h0, 0, 0, 1, 0));
    n = $urandom_range(0, 2);
    repeat (n) push_plain(1'($urandom), 4'h0, 3'($urandom), 16'h0000);
  endtask

  initial begin
    rst = 1'b0;
    #0 rst = 1'b1;

    // wash only, light mode, sensors immediate; then ignored starts and a spin-only run
    tbl[0]  = mk(1, 4'b0010, 3'b001, 0, 0, 0, 16'h0000);
    tbl[1]  = mk(0, 4'b0000, 3'b000, 1, 0, 0, pk(1, 0, 0, 0, 4'b0010, 0, 1, 0, 0));
    tbl[2]  = mk(1, 4'b0100, 3'b100, 0, 0, 0, pk(0, 0, 1, 0, 4'b0010, 3, 1, 0, 0));
    tbl[3]  = mk(0, 4'b0000, 3'b000, 0, 0, 0, pk(0, 0, 1, 0, 4'b0010, 2, 1, 0, 0));
    tbl[4]  = mk(0, 4'b0000, 3'b000, 0, 0, 0, pk(0, 0, 1, 0, 4'b0010, 1, 1, 0, 0));
    tbl[5]  = mk(0, 4'b0000, 3'b000, 0, 1, 0, pk(0, 1, 0, 0, 4'b0010, 0, 1, 0, 0));
    tbl[6]  = mk(0, 4'b0000, 3'b000, 0, 0, 0, pk(0, 0, 0, 0, 4'b0010, 0, 1, 0, 0));
    tbl[7]  = mk(0, 4'b0000, 3'b000, 0, 0, 0, pk(0, 0, 0, 0, 4'b0000, 0, 0, 1, 0));
    tbl[8]  = mk(1, 4'b0000, 3'b001, 1, 1, 0, 16'h0000);
    tbl[9]  = mk(1, 4'b1000, 3'b010, 0, 0, 0, 16'h0000);
    tbl[10] = mk(0, 4'b0000, 3'b000, 0, 0, 0, pk(0, 1, 0, 0, 4'b1000, 0, 1, 0, 0));
    tbl[11] = mk(0, 4'b0000, 3'b000, 0, 1, 0, pk(0, 1, 0, 0, 4'b1000, 0, 1, 0, 0));
    tbl[12] = mk(1, 4'b0001, 3'b001, 0, 0, 0, pk(0, 1, 1, 1, 4'b1000, 4, 1, 0, 0));
    tbl[13] = mk(0, 4'b0000, 3'b000, 1, 1, 1, pk(0, 0, 0, 0, 4'b1000, 3, 1, 0, 0));
    tbl[14] = mk(0, 4'b0000, 3'b000, 0, 0, 0, pk(0, 1, 1, 1, 4'b1000, 3, 1, 0, 0));
    tbl[15] = mk(0, 4'b0000, 3'b000, 0, 0, 0, pk(0, 1, 1, 1, 4'b1000, 2, 1, 0, 0));
    tbl[16] = mk(0, 4'b0000, 3'b000, 0, 0, 0, pk(0, 1, 1, 1, 4'b1000, 1, 1, 0, 0));
    tbl[17] = mk(0, 4'b0000, 3'b000, 0, 0, 0, pk(0, 0, 0, 0, 4'b1000, 0, 1, 0, 0));
    tbl[18] = mk(0, 4'b0000, 3'b000, 0, 0, 0, pk(0, 0, 0, 0, 4'b0000, 0, 0, 1, 0));
    tbl[19] = mk(0, 4'b0000, 3'b000, 0, 0, 0, 16'h0000);

    repeat (2) @(posedge clk);
    #1;
    check("reset", 16'h0000, 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) run_vec("table", tbl[i], i);

    // async reset in the middle of SPIN, then relaunch from the first stage
    drive(mk(1, 4'b1000, 3'b001, 0, 1, 0, 16'h0000));
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_spin", pk(0, 1, 1, 1, 4'b1000, 3, 1, 0, 0), 0);
    #1 rst = 1'b1;
    #1 check("async_rst", 16'h0000, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 16'h0000, 0);
    @(posedge clk); #1;
    drive(mk(1, 4'b0001, 3'b010, 1, 0, 0, 16'h0000));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("restart_first_stage", pk(1, 0, 0, 0, 4'b0001, 0, 1, 0, 0), 0);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // random programs against the timeline model
    gen_prog(4'b1111, 3'b010, 0);
    gen_prog(4'b0010, 3'b001, 1);
    gen_prog(4'b0011, 3'b100, 2);
    gen_prog(4'b1001, 3'b011, 0);
    for (int p = 0; p < 25; p++) begin
      int flt;
      flt = $urandom_range(0, 5);
      gen_prog(4'($urandom_range(1, 15)), 3'($urandom), (flt > 2) ? 0 : flt);
    end
    push_plain(1'b0, 4'h0, 3'b000, 16'h0000);
    for (int i = 0; i < q.size(); i++) run_vec("rand", q[i], i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
